// File: rtl/fetch_align_if.sv
// Signal bundle between fetch_align, the instruction memory, the redirect source and the decoder.
// master: the fetch stage side; slave: the environment side (memory, branch unit, decoder).
interface fetch_align_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_dout;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [31:0]           instr;
  logic [31:0]           instr_pc;
  logic                  instr_is_c;

  modport master (
    output imem_addr,
    input  imem_dout,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc,
    output instr_is_c
  );

  modport slave (
    input  imem_addr,
    output imem_dout,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc,
    input  instr_is_c
  );
endinterface

// File: rtl/fetch_align.sv
// Instruction fetch/realign stage: halfword buffer over a 1-cycle-latency word memory.
// Macro FETCH_RVC_EN enables 16-bit compressed instructions; undefined = 32-bit only.
module fetch_align #(
  parameter int          ADDR_WIDTH = 11,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_align_if.master bus
);

`ifdef FETCH_RVC_EN
  localparam int   HBN      = 3;
  localparam logic RST_DROP = RESET_PC[1];
`else
  localparam int   HBN      = 2;
  localparam logic RST_DROP = 1'b0;
`endif
  localparam int VN = HBN + 2;

  logic [ADDR_WIDTH-1:0] fptr_reg, fptr_next;
  logic [15:0]           hb_reg  [HBN];
  logic [15:0]           hb_next [HBN];
  logic [1:0]            hcnt_reg, hcnt_next;
  logic                  rsp_pend_reg, rsp_pend_next;
  logic                  drop_lo_reg, drop_lo_next;
  logic [31:0]           pc_reg, pc_next;

  logic [DATA_WIDTH-1:0] word;
  logic [15:0]           arr  [2];
  logic [15:0]           view [VN];
  logic [2:0]            arr_n, vcnt, cnt_after;
  logic [1:0]            n_cons;
  logic                  head_is_c, head_valid, fire, issue, rd_drop_lo;
  logic [31:0]           rd_pc;

  assign bus.imem_addr = fptr_reg;
  assign word          = bus.imem_dout;

  // The arriving response is treated as already appended behind the buffered halfwords,
  // so a word can be emitted in the cycle it returns from memory.
  assign arr[0] = drop_lo_reg ? word[31:16] : word[15:0];
  assign arr[1] = word[31:16];
  assign arr_n  = !rsp_pend_reg ? 3'd0 : (drop_lo_reg ? 3'd1 : 3'd2);
  assign vcnt   = {1'b0, hcnt_reg} + arr_n;

  generate
    for (genvar gi = 0; gi < VN; gi++) begin : g_view
      if (gi < HBN) begin : g_live
        assign view[gi] = (hcnt_reg >  2'(gi)) ? hb_reg[gi] :
                          (hcnt_reg == 2'(gi)) ? arr[0] : arr[1];
      end else begin : g_pad
        assign view[gi] = 16'h0;
      end
    end
  endgenerate

`ifdef FETCH_RVC_EN
  assign head_is_c  = (view[0][1:0] != 2'b11);
  assign rd_drop_lo = bus.redirect_pc[1];
  assign rd_pc      = bus.redirect_pc & ~32'd1;
`else
  assign head_is_c  = 1'b0;
  assign rd_drop_lo = 1'b0;
  assign rd_pc      = bus.redirect_pc & ~32'd3;
`endif

  assign head_valid = head_is_c ? (vcnt >= 3'd1) : (vcnt >= 3'd2);
  assign fire       = head_valid & bus.instr_ready & ~bus.redirect_valid;
  assign n_cons     = !fire ? 2'd0 : (head_is_c ? 2'd1 : 2'd2);
  assign cnt_after  = vcnt - {1'b0, n_cons};
  // Fetching only when at most one halfword remains keeps the buffer within three entries.
  assign issue      = ~bus.redirect_valid & (cnt_after <= 3'd1);

  generate
    for (genvar gi = 0; gi < HBN; gi++) begin : g_shift
      assign hb_next[gi] = (n_cons == 2'd0) ? view[gi] :
                           (n_cons == 2'd1) ? view[gi+1] : view[gi+2];
    end
  endgenerate

  always_comb begin
    hcnt_next     = cnt_after[1:0];
    rsp_pend_next = issue;
    fptr_next     = issue ? fptr_reg + ADDR_WIDTH'(1) : fptr_reg;
    drop_lo_next  = drop_lo_reg & ~rsp_pend_reg;
    pc_next       = pc_reg + {29'd0, n_cons, 1'b0};
    if (bus.redirect_valid) begin
      hcnt_next     = 2'd0;
      rsp_pend_next = 1'b0;
      fptr_next     = bus.redirect_pc[ADDR_WIDTH+1:2];
      drop_lo_next  = rd_drop_lo;
      pc_next       = rd_pc;
    end
  end

  always_comb begin
    bus.instr_valid = head_valid;
    bus.instr_is_c  = head_valid & head_is_c;
    bus.instr_pc    = pc_reg;
    bus.instr       = 32'h0;
    if (head_valid) begin
      bus.instr = head_is_c ? {16'h0, view[0]} : {view[1], view[0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fptr_reg     <= RESET_PC[ADDR_WIDTH+1:2];
      hcnt_reg     <= 2'd0;
      rsp_pend_reg <= 1'b0;
      drop_lo_reg  <= RST_DROP;
      pc_reg       <= RESET_PC;
      for (int i = 0; i < HBN; i++) hb_reg[i] <= 16'h0;
    end else begin
      fptr_reg     <= fptr_next;
      hcnt_reg     <= hcnt_next;
      rsp_pend_reg <= rsp_pend_next;
      drop_lo_reg  <= drop_lo_next;
      pc_reg       <= pc_next;
      for (int i = 0; i < HBN; i++) hb_reg[i] <= hb_next[i];
    end
  end

endmodule
